// File: rtl/fetch_controller_mc_pkg.sv
// Shared types and default sizing for the multi-channel fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        GETN  = 3'd2,
        FETCH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned DEF_NCH   = 4;
    localparam int unsigned DEF_CNT_W = 8;
    localparam int unsigned DEF_TO_W  = 6;

endpackage

// File: rtl/fetch_controller_mc_if.sv
// Command/channel bundle between the command front end and the fetch controller.
interface fetch_controller_mc_if
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] n_in;
    logic [NCH-1:0]   ready;
    logic             init;
    logic [NCH-1:0]   sel;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] fetched;

    modport master (
        output start, abort, n_in, ready,
        input  init, sel, busy, done, timeout, fetched
    );

    modport slave (
        input  start, abort, n_in, ready,
        output init, sel, busy, done, timeout, fetched
    );

endinterface

// File: rtl/fetch_controller_mc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping at NCH-1.
module rr_arbiter #(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   any
);

    localparam int unsigned PTR_W = $clog2(NCH);
    localparam logic [PTR_W:0] NCH_L = (PTR_W+1)'(NCH);

    logic [PTR_W:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            // one extra bit so ptr+i cannot overflow before the wrap
            idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (idx >= NCH_L) idx = idx - NCH_L;
            if (!any && req[idx[PTR_W-1:0]]) begin
                any                  = 1'b1;
                gnt[idx[PTR_W-1:0]]  = 1'b1;
                gnt_idx              = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fetch_controller_mc.sv
// Start/init/get-N/fetch sequencer granting one ready channel per cycle round-robin.
module fetch_controller_mc
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned NCH   = DEF_NCH,
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned TO_W  = DEF_TO_W
) (
    input logic                  clk,
    input logic                  rst,
    fetch_controller_mc_if.slave bus
);

    localparam int unsigned      PTR_W   = $clog2(NCH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NCH - 1);
    localparam logic [TO_W-1:0]  TMR_LIM = TO_W'((1 << TO_W) - 2);

    state_t           state, state_n;
    logic [CNT_W-1:0] fetched, fetched_n, n_reg, n_reg_n;
    logic [PTR_W-1:0] ptr, ptr_n;
    logic [TO_W-1:0]  timer, timer_n;
    logic             timeout, timeout_n;

    logic [NCH-1:0]   gnt;
    logic [PTR_W-1:0] gnt_idx;
    logic             any;

    logic             init_o, busy_o, done_o;
    logic [NCH-1:0]   sel_o;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req     (bus.ready),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fetched <= '0;
            n_reg   <= '0;
            ptr     <= '0;
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_n;
            fetched <= fetched_n;
            n_reg   <= n_reg_n;
            ptr     <= ptr_n;
            timer   <= timer_n;
            timeout <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        fetched_n = fetched;
        n_reg_n   = n_reg;
        ptr_n     = ptr;
        timer_n   = timer;
        timeout_n = timeout;
        init_o    = 1'b0;
        sel_o     = '0;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_n = PRE;
            end
            PRE: begin
                busy_o = 1'b1;
                if (bus.abort) state_n = IDLE;
                else begin
                    init_o = 1'b1;
                    if (!bus.start) state_n = GETN;
                end
            end
            GETN: begin
                busy_o = 1'b1;
                if (bus.abort) state_n = IDLE;
                else begin
                    n_reg_n   = bus.n_in;
                    fetched_n = '0;
                    timer_n   = '0;
                    timeout_n = 1'b0;
                    ptr_n     = '0;
                    state_n   = (bus.n_in == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy_o = 1'b1;
                // abort suppresses the grant, so a grant always implies a count
                if (bus.abort) state_n = IDLE;
                else if (any) begin
                    sel_o     = gnt;
                    fetched_n = fetched + CNT_W'(1);
                    ptr_n     = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);
                    timer_n   = '0;
                    if (fetched + CNT_W'(1) == n_reg) state_n = DONE;
                end else begin
                    timer_n = timer + TO_W'(1);
                    if (timer == TMR_LIM) begin
                        timeout_n = 1'b1;
                        state_n   = DONE;
                    end
                end
            end
            DONE: begin
                if (!bus.abort) done_o = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.init    = init_o;
    assign bus.sel     = sel_o;
    assign bus.busy    = busy_o;
    assign bus.done    = done_o;
    assign bus.timeout = timeout;
    assign bus.fetched = fetched;

endmodule

// File: tb/tb_fetch_controller_mc.sv
// Scoreboard bench for fetch_controller_mc: transaction model feeds an expectation queue, monitor checks.
module tb_fetch_controller_mc;

    localparam int unsigned NCH    = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned TO_W   = 3;
    localparam int          TO_LIM = (1 << TO_W) - 1;

    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_INIT  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_controller_mc_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    fetch_controller_mc #(.NCH(NCH), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int kind;
        int val;
        int val2;
    } ev_t;

    typedef struct {
        string       name;
        logic [15:0] v;
    } snap_t;

    ev_t   exp_q[$];
    snap_t snap_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    fin   = 1'b0;

    // ---------------- monitor ----------------
    initial begin : monitor
        int          init_run;
        ev_t         e;
        snap_t       s;
        logic [15:0] act;
        logic [3:0]  want;
        init_run = 0;
        forever begin
            @(negedge clk);
            act = {bus.init, bus.busy, bus.done, bus.timeout, bus.sel, bus.fetched};
            while (snap_q.size() > 0) begin
                s = snap_q.pop_front();
                n_cmp++;
                if (act !== s.v) begin
                    n_bad++;
                    $display("FAIL %s: {init,busy,done,timeout,sel,fetched}=%h expected %h", s.name, act, s.v);
                end
            end
            if (rst !== 1'b0) init_run = 0;
            else begin
                if (bus.sel !== '0) begin
                    n_cmp++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_GRANT) begin
                        n_bad++;
                        $display("FAIL grant: sel=%b while no grant expected", bus.sel);
                    end else begin
                        e = exp_q.pop_front();
                        want = 4'(1 << e.val);
                        if (bus.sel !== want) begin
                            n_bad++;
                            $display("FAIL grant: sel=%b expected %b", bus.sel, want);
                        end
                    end
                end
                if (bus.done !== 1'b0) begin
                    n_cmp++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_DONE) begin
                        n_bad++;
                        $display("FAIL done: done=%b while no completion expected", bus.done);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(bus.fetched) != e.val || int'(bus.timeout) != e.val2) begin
                            n_bad++;
                            $display("FAIL done: fetched=%0d timeout=%b expected fetched=%0d timeout=%0d",
                                     bus.fetched, bus.timeout, e.val, e.val2);
                        end
                    end
                end
                if (bus.init === 1'b1) init_run++;
                else if (init_run > 0) begin
                    n_cmp++;
                    if (exp_q.size() == 0 || exp_q[0].kind != EV_INIT) begin
                        n_bad++;
                        $display("FAIL init: init burst of %0d cycles not expected", init_run);
                    end else begin
                        e = exp_q.pop_front();
                        if (init_run != e.val) begin
                            n_bad++;
                            $display("FAIL init: high for %0d cycles expected %0d", init_run, e.val);
                        end
                    end
                    init_run = 0;
                end
            end
            if (fin) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL leftover: %0d expected events never seen, expected 0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic st, input logic [CNT_W-1:0] n, input logic [NCH-1:0] r,
                         input logic ab, input logic rs);
        @(posedge clk);
        #1;
        bus.start = st;
        bus.n_in  = n;
        bus.ready = r;
        bus.abort = ab;
        rst       = rs;
    endtask

    function automatic logic [NCH-1:0] gen_ready(input int mode, input int c);
        case (mode)
            0:       return 4'hF;
            1:       return 4'($urandom_range(0, 15));
            2:       return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            3:       return 4'b1010;
            default: return (c == 0) ? 4'hF : 4'h0;
        endcase
    endfunction

    // Transaction model: walk FETCH cycles, granting the first ready channel at or after
    // the channel following the previous grant, until n grants, an abort/reset, or TO_LIM idle cycles.
    task automatic run_op(input int n, input int s, input int mode, input int abort_at, input int rst_at);
        logic [NCH-1:0] rq[$];
        logic [NCH-1:0] r;
        int             ptr, cnt, idle, g, j;
        bit             done_exp, to;
        ptr = 0; cnt = 0; idle = 0; done_exp = 1'b0; to = 1'b0;
        exp_q.push_back('{EV_INIT, s, 0});
        if (n == 0) done_exp = 1'b1;
        else begin
            for (int c = 0; c < 4096; c++) begin
                r = gen_ready(mode, c);
                if (c == rst_at) r = '0;
                rq.push_back(r);
                if (c == abort_at || c == rst_at) break;
                g = -1;
                for (int k = 0; k < NCH; k++) begin
                    j = (ptr + k) % NCH;
                    if (g < 0 && ((r >> j) & 4'd1) != 4'd0) g = j;
                end
                if (g >= 0) begin
                    exp_q.push_back('{EV_GRANT, g, 0});
                    cnt++;
                    ptr  = (g + 1) % NCH;
                    idle = 0;
                    if (cnt == n) begin
                        done_exp = 1'b1;
                        break;
                    end
                end else begin
                    idle++;
                    if (idle == TO_LIM) begin
                        to       = 1'b1;
                        done_exp = 1'b1;
                        break;
                    end
                end
            end
        end
        if (done_exp) exp_q.push_back('{EV_DONE, cnt, int'(to)});

        for (int i = 0; i < s; i++) drive(1'b1, CNT_W'(n), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drive(1'b0, CNT_W'(n), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drive(1'b0, CNT_W'(n), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        for (int c = 0; c < rq.size(); c++)
            drive(1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 255)), rq[c],
                  1'(c == abort_at), 1'(c == rst_at));
        if (done_exp)
            drive(1'($urandom_range(0, 1)), CNT_W'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        if (rst_at >= 0) snap_q.push_back('{"after_reset", 16'h0000});
        else             snap_q.push_back('{"after_op", {3'b000, to, 4'h0, 8'(cnt)}});
        drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin : stimulus
        int n, s, mode, ab;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.n_in  = '0;
        bus.ready = '0;
        drive(1'b0, '0, '0, 1'b1, 1'b1);
        drive(1'b1, '0, 4'hF, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        snap_q.push_back('{"reset_state", 16'h0000});
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        run_op(5,   3, 0, -1, -1);   // basic run
        run_op(4,   2, 3, -1, -1);   // round-robin skip over 1010
        run_op(0,   1, 0, -1, -1);   // zero count
        run_op(3,   1, 4, -1, -1);   // one grant then stall to timeout
        run_op(10,  2, 0,  3, -1);   // abort in 4th FETCH cycle
        run_op(10,  2, 0, -1,  3);   // reset mid-fetch
        run_op(1,   1, 0, -1, -1);   // first grant after reset is channel 0
        run_op(255, 1, 0, -1, -1);   // maximum count

        for (int t = 0; t < 40; t++) begin
            n    = $urandom_range(0, 12);
            s    = $urandom_range(1, 4);
            mode = $urandom_range(0, 4);
            ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            run_op(n, s, mode, ab, -1);
        end

        drive(1'b0, '0, '0, 1'b0, 1'b0);
        fin = 1'b1;
        #100;
        $display("FAIL watchdog: monitor did not reach summary");
        $fatal(1);
    end

endmodule
